l2_port_arbiter: RTL and testbench
==================================

Name: l2_port_arbiter

Overview:
Registered arbiter sharing the single L2/physical-memory line port between the I-cache miss path and the D-cache miss/writeback path.
- Latches the winning request's address and write data, then drives the shared port until mem_resp.
- Returns a one-cycle response with registered read data to the winner.
- Data-side priority, bounded by a starvation limit so instruction fetch always makes progress.

Parameters:
ADDR_W, 32, address width in bits
LINE_W, 256, cache line width in bits
STARVE_MAX, 4, consecutive D grants allowed while an I request waits before I is forced to win (1..15)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
imem_read  input  1  I-cache line read request, held until imem_resp
imem_addr  input  ADDR_W  I-cache line address
imem_rdata  output  LINE_W  line returned to I-cache
imem_resp  output  1  one-cycle completion pulse to I-cache
dmem_read  input  1  D-cache line read request, held until dmem_resp
dmem_write  input  1  D-cache line write request, held until dmem_resp
dmem_addr  input  ADDR_W  D-cache line address
dmem_wdata  input  LINE_W  D-cache writeback line
dmem_rdata  output  LINE_W  line returned to D-cache
dmem_resp  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  shared-port read strobe
mem_write  output  1  shared-port write strobe
mem_addr  output  ADDR_W  shared-port address (latched)
mem_wdata  output  LINE_W  shared-port write data (latched)
mem_rdata  input  LINE_W  read data, valid when mem_resp=1
mem_resp  input  1  shared-port completion

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: state=IDLE, starve_cnt=0, and every output register at 0 (mem_read, mem_write, mem_addr, mem_wdata, imem_resp, dmem_resp, imem_rdata, dmem_rdata).
- All outputs come straight from flops; no combinational input-to-output paths.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE arbitration, evaluated on each edge:
  - If a D request exists (dmem_read|dmem_write) and not (imem_read && starve_cnt==STARVE_MAX): grant D.
  - Else if imem_read: grant I.
  - Else stay in IDLE.
- On a grant edge:
  - mem_addr is latched from the winner; for a D write, mem_wdata is latched from dmem_wdata.
  - For I, or a D write: mem_write=dmem_write (0 for I), mem_read=!mem_write.
  - For a D read: mem_read=1.
  - dmem_read and dmem_write both high counts as a write; the read is ignored.
- Starvation counter:
  - D grant with imem_read high: starve_cnt increments, saturating at STARVE_MAX.
  - Any I grant, or a D grant with imem_read low: starve_cnt clears to 0.
- BUSY_I / BUSY_D:
  - mem_read/mem_write are held, and mem_addr/mem_wdata stay stable, until mem_resp.
  - Requester inputs are not re-sampled; a requester dropping its request mid-transaction does not abort it.
  - On the mem_resp edge: strobes clear to 0; the winner's rdata register captures mem_rdata (read only; for a write the rdata register holds its prior value); go to DONE.
- DONE:
  - Lasts exactly one cycle, with the winner's resp=1.
  - No grant is evaluated in DONE, because the requester still shows its old request that cycle.
  - Next state is IDLE; resp returns to 0.
- Latency:
  - Request seen in IDLE at edge n: strobe high from edge n.
  - mem_resp sampled at edge m: requester resp high from edge m to m+1.
  - Earliest next grant is edge m+2.
  - Minimum grant-to-grant spacing is 3 cycles when mem_resp arrives in the first busy cycle.
- mem_resp in IDLE or DONE is ignored; no state or output changes.
- imem_resp and dmem_resp are never high in the same cycle.
- Reset mid-transaction: on the rst edge everything returns to reset values; the in-flight port transaction is abandoned and no resp is issued.

Test Plan:
- I-only read: imem_read=1, addr 0x0000_1040; mem_resp two cycles after mem_read rises, rdata=0xA5..A5 -> mem_addr=0x1040, mem_read high 2 cycles, imem_resp one cycle after mem_resp, imem_rdata=0xA5..A5, dmem_resp never high.
- Simultaneous I and D: imem_read and dmem_write asserted together -> D granted first (mem_write=1, mem_wdata=dmem_wdata); I granted at edge m+2 after the D mem_resp.
- Starvation: dmem_read continuously re-asserted, imem_read held high, STARVE_MAX=4 -> exactly 4 D grants, then an I grant, starve_cnt=0 afterwards.
- Request dropped mid-transaction: dmem_read released in BUSY_D before mem_resp -> mem_read stays high until mem_resp; dmem_resp still pulses once.
- Reset mid-transaction: rst pulsed during BUSY_I -> next cycle mem_read=0, state IDLE, no imem_resp; a later imem_read is granted normally.
- Spurious mem_resp in IDLE, and read+write both high -> no response pulses from the spurious mem_resp; the read+write request issues as a write with mem_read=0.

Source files
------------

// File: rtl/l2_port_arbiter_if.sv
// Bundle of the I-cache miss port, D-cache miss/writeback port and the shared
// L2/memory line port.
//   slave  : arbiter view (accepts cache requests, drives the memory port)
//   master : environment view (issues cache requests, answers the memory port)
interface l2_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  // I-cache side
  logic              imem_read;
  logic [ADDR_W-1:0] imem_addr;
  logic [LINE_W-1:0] imem_rdata;
  logic              imem_resp;
  // D-cache side
  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_addr;
  logic [LINE_W-1:0] dmem_wdata;
  logic [LINE_W-1:0] dmem_rdata;
  logic              dmem_resp;
  // Shared memory port
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  imem_read, imem_addr,
    output imem_rdata, imem_resp,
    input  dmem_read, dmem_write, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_resp,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output imem_read, imem_addr,
    input  imem_rdata, imem_resp,
    output dmem_read, dmem_write, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// Registered arbiter sharing one L2/memory line port between the I-cache miss
// path and the D-cache miss/writeback path. D has priority, but after
// STARVE_MAX consecutive D grants with an I request waiting, I is forced to win.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : l2_port_arbiter_if.slave (I-cache, D-cache and memory port signals)
// All outputs are driven directly from flops.
module l2_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  l2_port_arbiter_if.slave      bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              imem_resp_q, imem_resp_d;
  logic              dmem_resp_q, dmem_resp_d;
  logic [LINE_W-1:0] imem_rdata_q, imem_rdata_d;
  logic [LINE_W-1:0] dmem_rdata_q, dmem_rdata_d;

  logic d_req_c;
  logic i_forced_c;
  logic grant_d_c;
  logic grant_i_c;

  // Arbitration decision, only acted on in IDLE
  assign d_req_c    = bus.dmem_read | bus.dmem_write;
  assign i_forced_c = bus.imem_read && (starve_cnt_q == CNT_W'(STARVE_MAX));
  assign grant_d_c  = (state_q == IDLE) && d_req_c && !i_forced_c;
  assign grant_i_c  = (state_q == IDLE) && !grant_d_c && bus.imem_read;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      imem_resp_q  <= 1'b0;
      dmem_resp_q  <= 1'b0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      imem_resp_q  <= imem_resp_d;
      dmem_resp_q  <= dmem_resp_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d_c)      state_d = BUSY_D;
        else if (grant_i_c) state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_resp) state_d = DONE;
      end
      // Requester still shows its old request here, so never arbitrate in DONE
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and starvation counter
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    imem_rdata_d = imem_rdata_q;
    dmem_rdata_d = dmem_rdata_q;
    imem_resp_d  = 1'b0;
    dmem_resp_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d_c) begin
          mem_addr_d = bus.dmem_addr;
          // Read+write together issues as a write
          if (bus.dmem_write) begin
            mem_wdata_d = bus.dmem_wdata;
            mem_write_d = 1'b1;
            mem_read_d  = 1'b0;
          end else begin
            mem_write_d = 1'b0;
            mem_read_d  = 1'b1;
          end
          if (!bus.imem_read) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q < CNT_W'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else if (grant_i_c) begin
          mem_addr_d   = bus.imem_addr;
          mem_write_d  = 1'b0;
          mem_read_d   = 1'b1;
          starve_cnt_d = '0;
        end
      end
      BUSY_I: begin
        if (bus.mem_resp) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          imem_rdata_d = bus.mem_rdata;
          imem_resp_d  = 1'b1;
        end
      end
      BUSY_D: begin
        if (bus.mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          // Writes leave the returned-line register untouched
          if (mem_read_q) dmem_rdata_d = bus.mem_rdata;
          dmem_resp_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.imem_resp  = imem_resp_q;
  assign bus.dmem_resp  = dmem_resp_q;
  assign bus.imem_rdata = imem_rdata_q;
  assign bus.dmem_rdata = dmem_rdata_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
module tb_l2_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic both_resp_seen;

  l2_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_resp && bus.dmem_resp) both_resp_seen = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_read  = 1'b0;
    bus.imem_addr  = '0;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_resp   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_vec++;
    if (dut.state_q !== 2'd0 || dut.starve_cnt_q !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: state=%0d cnt=%0d exp 0/0", dut.state_q, dut.starve_cnt_q);
    end
    n_vec++;
    if ({bus.mem_read, bus.mem_write, bus.imem_resp, bus.dmem_resp} !== 4'b0000 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0 ||
        bus.imem_rdata !== '0 || bus.dmem_rdata !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rd=%b wr=%b iresp=%b dresp=%b addr=%h exp all 0",
               bus.mem_read, bus.mem_write, bus.imem_resp, bus.dmem_resp, bus.mem_addr);
    end
  endtask

  task automatic test_i_read();
    bus.imem_read = 1'b1;
    bus.imem_addr = 32'h0000_1040;
    step();
    n_vec++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0000_1040) begin
      n_err++;
      $display("FAIL i_grant: rd=%b wr=%b addr=%h exp 1/0/00001040", bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    step();
    n_vec++;
    if (bus.mem_read !== 1'b1 || bus.imem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL i_hold: rd=%b iresp=%b exp 1/0", bus.mem_read, bus.imem_resp);
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {32{8'hA5}};
    step();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    n_vec++;
    if (bus.imem_resp !== 1'b1 || bus.mem_read !== 1'b0 || bus.imem_rdata !== {32{8'hA5}}) begin
      n_err++;
      $display("FAIL i_resp: iresp=%b rd=%b rdata=%h exp 1/0/a5..", bus.imem_resp, bus.mem_read, bus.imem_rdata);
    end
    bus.imem_read = 1'b0;
    step();
    n_vec++;
    if (bus.imem_resp !== 1'b0 || bus.dmem_resp !== 1'b0 || dut.state_q !== 2'd0) begin
      n_err++;
      $display("FAIL i_done: iresp=%b dresp=%b state=%0d exp 0/0/0", bus.imem_resp, bus.dmem_resp, dut.state_q);
    end
  endtask

  task automatic test_simultaneous();
    bus.imem_read  = 1'b1;
    bus.imem_addr  = 32'h0000_3000;
    bus.dmem_write = 1'b1;
    bus.dmem_addr  = 32'h0000_2000;
    bus.dmem_wdata = {32{8'h5A}};
    step();
    n_vec++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 32'h0000_2000 ||
        bus.mem_wdata !== {32{8'h5A}}) begin
      n_err++;
      $display("FAIL sim_d_grant: wr=%b rd=%b addr=%h wdata=%h exp 1/0/00002000/5a..",
               bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
    end
    n_vec++;
    if (dut.starve_cnt_q !== 4'd1) begin
      n_err++;
      $display("FAIL sim_starve: cnt=%0d exp 1", dut.starve_cnt_q);
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {32{8'h77}};
    step();
    bus.mem_resp = 1'b0;
    n_vec++;
    if (bus.dmem_resp !== 1'b1 || bus.mem_write !== 1'b0 || bus.dmem_rdata !== '0 || bus.imem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL sim_d_resp: dresp=%b wr=%b drdata=%h iresp=%b exp 1/0/0/0",
               bus.dmem_resp, bus.mem_write, bus.dmem_rdata, bus.imem_resp);
    end
    // D request still visible during DONE; must not be re-granted
    step();
    n_vec++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.dmem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL sim_no_grant_done: rd=%b wr=%b dresp=%b exp 0/0/0", bus.mem_read, bus.mem_write, bus.dmem_resp);
    end
    bus.dmem_write = 1'b0;
    step();
    n_vec++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0000_3000) begin
      n_err++;
      $display("FAIL sim_i_grant: rd=%b wr=%b addr=%h exp 1/0/00003000", bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {32{8'h11}};
    step();
    bus.mem_resp  = 1'b0;
    bus.imem_read = 1'b0;
    n_vec++;
    if (bus.imem_resp !== 1'b1 || bus.imem_rdata !== {32{8'h11}}) begin
      n_err++;
      $display("FAIL sim_i_resp: iresp=%b rdata=%h exp 1/11..", bus.imem_resp, bus.imem_rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    logic [ADDR_W-1:0] daddr;
    bus.imem_read = 1'b1;
    bus.imem_addr = 32'h0000_4000;
    bus.dmem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      daddr = 32'h0000_5000 + ADDR_W'(k * 32'h40);
      bus.dmem_addr = daddr;
      step();
      n_vec++;
      if (bus.mem_read !== 1'b1 || bus.mem_addr !== daddr || dut.starve_cnt_q !== 4'(k + 1)) begin
        n_err++;
        $display("FAIL starve_d_grant%0d: rd=%b addr=%h cnt=%0d exp 1/%h/%0d",
                 k, bus.mem_read, bus.mem_addr, dut.starve_cnt_q, daddr, k + 1);
      end
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = {32{8'(8'h20 + k)}};
      step();
      bus.mem_resp = 1'b0;
      n_vec++;
      if (bus.dmem_resp !== 1'b1 || bus.dmem_rdata !== {32{8'(8'h20 + k)}}) begin
        n_err++;
        $display("FAIL starve_d_resp%0d: dresp=%b rdata=%h", k, bus.dmem_resp, bus.dmem_rdata);
      end
      step();
    end
    // Fifth opportunity: I must win despite the pending D read
    step();
    n_vec++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0000_4000 || dut.starve_cnt_q !== 4'd0 ||
        dut.state_q !== 2'd1) begin
      n_err++;
      $display("FAIL starve_i_grant: rd=%b addr=%h cnt=%0d state=%0d exp 1/00004000/0/1",
               bus.mem_read, bus.mem_addr, dut.starve_cnt_q, dut.state_q);
    end
    bus.dmem_read = 1'b0;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {32{8'h44}};
    step();
    bus.mem_resp  = 1'b0;
    bus.imem_read = 1'b0;
    n_vec++;
    if (bus.imem_resp !== 1'b1 || bus.dmem_resp !== 1'b0 || bus.imem_rdata !== {32{8'h44}}) begin
      n_err++;
      $display("FAIL starve_i_resp: iresp=%b dresp=%b rdata=%h", bus.imem_resp, bus.dmem_resp, bus.imem_rdata);
    end
    step();
  endtask

  task automatic test_drop_request();
    int pulses;
    pulses = 0;
    bus.dmem_read = 1'b1;
    bus.dmem_addr = 32'h0000_6000;
    step();
    bus.dmem_read = 1'b0;
    step();
    n_vec++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0000_6000) begin
      n_err++;
      $display("FAIL drop_hold: rd=%b addr=%h exp 1/00006000", bus.mem_read, bus.mem_addr);
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {32{8'h3C}};
    step();
    bus.mem_resp = 1'b0;
    if (bus.dmem_resp === 1'b1) pulses++;
    n_vec++;
    if (bus.mem_read !== 1'b0 || bus.dmem_rdata !== {32{8'h3C}}) begin
      n_err++;
      $display("FAIL drop_data: rd=%b rdata=%h exp 0/3c..", bus.mem_read, bus.dmem_rdata);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.dmem_resp === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 1 || dut.state_q !== 2'd0) begin
      n_err++;
      $display("FAIL drop_pulses: pulses=%0d state=%0d exp 1/0", pulses, dut.state_q);
    end
  endtask

  task automatic test_reset_mid();
    bus.imem_read = 1'b1;
    bus.imem_addr = 32'h0000_7000;
    step();
    step();
    n_vec++;
    if (bus.mem_read !== 1'b1 || dut.state_q !== 2'd1) begin
      n_err++;
      $display("FAIL rstmid_busy: rd=%b state=%0d exp 1/1", bus.mem_read, dut.state_q);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (bus.mem_read !== 1'b0 || dut.state_q !== 2'd0 || bus.imem_resp !== 1'b0 ||
        bus.mem_addr !== '0 || bus.dmem_rdata !== '0) begin
      n_err++;
      $display("FAIL rstmid_cleared: rd=%b state=%0d iresp=%b addr=%h exp 0/0/0/0",
               bus.mem_read, dut.state_q, bus.imem_resp, bus.mem_addr);
    end
    step();
    n_vec++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0000_7000 || bus.imem_resp !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_regrant: rd=%b addr=%h iresp=%b exp 1/00007000/0", bus.mem_read, bus.mem_addr, bus.imem_resp);
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {32{8'h96}};
    step();
    bus.mem_resp  = 1'b0;
    bus.imem_read = 1'b0;
    n_vec++;
    if (bus.imem_resp !== 1'b1 || bus.imem_rdata !== {32{8'h96}}) begin
      n_err++;
      $display("FAIL rstmid_resp: iresp=%b rdata=%h exp 1/96..", bus.imem_resp, bus.imem_rdata);
    end
    step();
  endtask

  task automatic test_spurious_and_rw();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {32{8'hEE}};
    step();
    step();
    bus.mem_resp = 1'b0;
    n_vec++;
    if (bus.imem_resp !== 1'b0 || bus.dmem_resp !== 1'b0 || bus.mem_read !== 1'b0 ||
        bus.mem_write !== 1'b0 || dut.state_q !== 2'd0 || bus.dmem_rdata !== '0) begin
      n_err++;
      $display("FAIL spurious: iresp=%b dresp=%b rd=%b wr=%b state=%0d exp all 0",
               bus.imem_resp, bus.dmem_resp, bus.mem_read, bus.mem_write, dut.state_q);
    end
    bus.dmem_read  = 1'b1;
    bus.dmem_write = 1'b1;
    bus.dmem_addr  = 32'h0000_8000;
    bus.dmem_wdata = {32{8'hC3}};
    step();
    n_vec++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 32'h0000_8000 ||
        bus.mem_wdata !== {32{8'hC3}}) begin
      n_err++;
      $display("FAIL rw_as_write: wr=%b rd=%b addr=%h wdata=%h exp 1/0/00008000/c3..",
               bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = {32{8'hFF}};
    step();
    bus.mem_resp = 1'b0;
    n_vec++;
    if (bus.dmem_resp !== 1'b1 || bus.dmem_rdata !== '0 || bus.mem_write !== 1'b0) begin
      n_err++;
      $display("FAIL rw_resp: dresp=%b rdata=%h wr=%b exp 1/0/0", bus.dmem_resp, bus.dmem_rdata, bus.mem_write);
    end
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    step();
    step();
  endtask

  task automatic test_resp_exclusive();
    n_vec++;
    if (both_resp_seen !== 1'b0) begin
      n_err++;
      $display("FAIL resp_exclusive: both responses seen high together=%b exp 0", both_resp_seen);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    both_resp_seen = 1'b0;
    rst = 1'b1;
    test_reset();
    test_i_read();
    test_simultaneous();
    test_reset();
    test_starvation();
    test_drop_request();
    test_reset_mid();
    test_spurious_and_rw();
    test_resp_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
